// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags and ROB commit write-back.
// Define REGFILE_BYPASS_EN to forward a releasing commit to same-cycle source lookups.
module reg_file_rename #(
   parameter int NUM_REGS   = 32,
   parameter int TAG_WIDTH  = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  flush,
   input  logic                  commit_valid,
   input  logic [4:0]            commit_rd,
   input  logic [DATA_WIDTH-1:0] commit_res,
   input  logic [TAG_WIDTH-1:0]  commit_dependency,
   input  logic                  rename_valid,
   input  logic [4:0]            rename_rd,
   input  logic [TAG_WIDTH-1:0]  rename_tag,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   output logic                  rs1_busy,
   output logic [TAG_WIDTH-1:0]  rs1_tag,
   output logic [DATA_WIDTH-1:0] rs1_value,
   output logic                  rs2_busy,
   output logic [TAG_WIDTH-1:0]  rs2_tag,
   output logic [DATA_WIDTH-1:0] rs2_value
);

   logic [DATA_WIDTH-1:0] value_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] value_d [NUM_REGS];
   logic [TAG_WIDTH-1:0]  tag_q   [NUM_REGS];
   logic [TAG_WIDTH-1:0]  tag_d   [NUM_REGS];

   // x0 is never updated, so it holds its reset value of zero forever.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         value_d[i] = value_q[i];
         tag_d[i]   = tag_q[i];
         if (i != 0 && rdy) begin
            if (commit_valid && commit_rd == 5'(i)) begin
               value_d[i] = commit_res;
               // Only the current owner may release; a younger rename keeps its tag.
               if (tag_q[i] == commit_dependency)
                  tag_d[i] = '0;
            end
            if (flush)
               tag_d[i] = '0;
            else if (rename_valid && rename_rd == 5'(i))
               tag_d[i] = rename_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rst) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end else begin
            value_q[i] <= value_d[i];
            tag_q[i]   <= tag_d[i];
         end
      end
   end

   // Returns {busy, tag, value} for one source index.
   function automatic logic [TAG_WIDTH+DATA_WIDTH:0] lookup(input logic [4:0] rs);
      logic [TAG_WIDTH-1:0] t;
      t = tag_q[rs];
`ifdef REGFILE_BYPASS_EN
      if (commit_valid && rs != 5'd0 && commit_rd == rs && commit_dependency == t)
         return {1'b0, {TAG_WIDTH{1'b0}}, commit_res};
`endif
      if (rs == 5'd0 || t == '0)
         return {1'b0, {TAG_WIDTH{1'b0}}, (rs == 5'd0) ? {DATA_WIDTH{1'b0}} : value_q[rs]};
      return {1'b1, t, {DATA_WIDTH{1'b0}}};
   endfunction

   assign {rs1_busy, rs1_tag, rs1_value} = lookup(rs1);
   assign {rs2_busy, rs2_tag, rs2_value} = lookup(rs2);

endmodule
